// File: rtl/pin_mux_sel_ctrl_if.sv
// Reconfiguration request channel between a pin-mux client and pin_mux_sel_ctrl.
// The client owns valid/pin/func; the controller answers with ready/done/err pulses.
interface pin_mux_sel_ctrl_if #(
  parameter int PW = 5
);
  logic          req_valid;
  logic          req_ready;
  logic [PW-1:0] req_pin;
  logic [1:0]    req_func;
  logic          done;
  logic          err;

  modport master (
    output req_valid, req_pin, req_func,
    input  req_ready, done, err
  );

  modport slave (
    input  req_valid, req_pin, req_func,
    output req_ready, done, err
  );
endinterface

// File: rtl/pin_mux_sel_ctrl.sv
// Break-before-make pin function switcher: tristates the pad for GUARD cycles,
// changes the mux select, then holds the tristate for another GUARD cycles.
//
// state   | meaning
// IDLE    | accepting requests; reject and same-function requests finish here
// QUIESCE | pad forced tristate, old function still selected
// SETTLE  | new function selected, pad still forced tristate
module pin_mux_sel_ctrl #(
  parameter int COUNT = 32,
  parameter int GUARD = 4,
  localparam int PW = (COUNT > 2) ? $clog2(COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pin_mux_sel_ctrl_if.slave    req,
  output logic                 busy,
  output logic [COUNT-1:0]     sel0,
  output logic [COUNT-1:0]     sel1,
  input  logic [COUNT-1:0]     mux_oeb,
  output logic [COUNT-1:0]     io_oeb
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_QUIESCE = 2'd1;
  localparam logic [1:0] ST_SETTLE  = 2'd2;

  localparam logic [7:0]  CNT_LOAD = 8'(GUARD - 1);
  localparam logic [31:0] COUNT_U  = 32'(COUNT);

  logic [1:0]       state;
  logic [7:0]       cnt;
  logic [PW-1:0]    pin_q;
  logic [1:0]       func_q;
  logic [COUNT-1:0] frc;
  logic             done_q;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      pin_q  <= '0;
      func_q <= '0;
      sel0   <= '0;
      sel1   <= '0;
      frc    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req.req_valid) begin
            if (32'(req.req_pin) >= COUNT_U) begin
              err_q <= 1'b1;
            end else if ({sel1[req.req_pin], sel0[req.req_pin]} == req.req_func) begin
              done_q <= 1'b1;
            end else begin
              pin_q            <= req.req_pin;
              func_q           <= req.req_func;
              frc[req.req_pin] <= 1'b1;
              cnt              <= CNT_LOAD;
              state            <= ST_QUIESCE;
            end
          end
        end
        ST_QUIESCE: begin
          if (cnt == 8'd0) begin
            sel0[pin_q] <= func_q[0];
            sel1[pin_q] <= func_q[1];
            cnt         <= CNT_LOAD;
            state       <= ST_SETTLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_SETTLE: begin
          if (cnt == 8'd0) begin
            frc[pin_q] <= 1'b0;
            done_q     <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Only one pin is ever in a switch sequence, so frc is one-hot or zero.
  assign io_oeb        = mux_oeb | frc;
  assign busy          = (state != ST_IDLE);
  assign req.req_ready = (state == ST_IDLE);
  assign req.done      = done_q;
  assign req.err       = err_q;

endmodule

// File: tb/tb_pin_mux_sel_ctrl.sv
// Bench for pin_mux_sel_ctrl: instance A (COUNT=32, GUARD=4) and instance B
// (COUNT=20, GUARD=1) checked against a request-timeline reference model.
module tb_pin_mux_sel_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        busy_a, busy_b;
  logic [31:0] sel0_a, sel1_a, moa, ioa;
  logic [19:0] sel0_b, sel1_b, mob, iob;

  pin_mux_sel_ctrl_if #(.PW(5)) bus_a ();
  pin_mux_sel_ctrl_if #(.PW(5)) bus_b ();

  pin_mux_sel_ctrl #(.COUNT(32), .GUARD(4)) dut_a (
    .clk(clk), .rst(rst), .req(bus_a.slave), .busy(busy_a),
    .sel0(sel0_a), .sel1(sel1_a), .mux_oeb(moa), .io_oeb(ioa)
  );

  pin_mux_sel_ctrl #(.COUNT(20), .GUARD(1)) dut_b (
    .clk(clk), .rst(rst), .req(bus_b.slave), .busy(busy_b),
    .sel0(sel0_b), .sel1(sel1_b), .mux_oeb(mob), .io_oeb(iob)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: per-pin function table plus "cycles since handshake" of the active switch.
  int m_func [2][64];
  int m_phase [2];
  int m_pin [2];
  int m_nf [2];
  bit m_done [2];
  bit m_err [2];

  task automatic model_step(input int k, input bit r, input bit v, input int pin,
                            input int func, input int g, input int n);
    if (r) begin
      for (int i = 0; i < 64; i++) m_func[k][i] = 0;
      m_phase[k] = 0;
      m_done[k]  = 0;
      m_err[k]   = 0;
      return;
    end
    m_done[k] = 0;
    m_err[k]  = 0;
    if (m_phase[k] != 0) begin
      m_phase[k]++;
      if (m_phase[k] == g + 1) m_func[k][m_pin[k]] = m_nf[k];
      if (m_phase[k] > 2 * g) begin
        m_phase[k] = 0;
        m_done[k]  = 1;
      end
    end else if (v) begin
      if (pin >= n) m_err[k] = 1;
      else if (m_func[k][pin] == func) m_done[k] = 1;
      else begin
        m_phase[k] = 1;
        m_pin[k]   = pin;
        m_nf[k]    = func;
      end
    end
  endtask

  function automatic logic [99:0] exp_a();
    logic [31:0] s0, s1, f;
    f = '0;
    for (int i = 0; i < 32; i++) begin
      s0[i] = m_func[0][i][0];
      s1[i] = m_func[0][i][1];
    end
    if (m_phase[0] != 0) f[m_pin[0]] = 1'b1;
    return {m_phase[0] == 0, m_phase[0] != 0, m_done[0], m_err[0], s1, s0, moa | f};
  endfunction

  function automatic logic [63:0] exp_b();
    logic [19:0] s0, s1, f;
    f = '0;
    for (int i = 0; i < 20; i++) begin
      s0[i] = m_func[1][i][0];
      s1[i] = m_func[1][i][1];
    end
    if (m_phase[1] != 0) f[m_pin[1]] = 1'b1;
    return {m_phase[1] == 0, m_phase[1] != 0, m_done[1], m_err[1], s1, s0, mob | f};
  endfunction

  logic [99:0] obs_a;
  logic [63:0] obs_b;
  assign obs_a = {bus_a.req_ready, busy_a, bus_a.done, bus_a.err, sel1_a, sel0_a, ioa};
  assign obs_b = {bus_b.req_ready, busy_b, bus_b.done, bus_b.err, sel1_b, sel0_b, iob};

  task automatic clk_step();
    @(posedge clk);
    model_step(0, rst, bus_a.req_valid, int'(bus_a.req_pin), int'(bus_a.req_func), 4, 32);
    model_step(1, rst, bus_b.req_valid, int'(bus_b.req_pin), int'(bus_b.req_func), 1, 20);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    moa = $urandom();
    mob = 20'($urandom());
    clk_step();
    clk_step();
    rst = 1'b0;
    vectors++;
    if (obs_a !== exp_a()) begin
      miscompares++;
      $display("FAIL reset_a: got %h want %h", obs_a, exp_a());
    end
    vectors++;
    if (obs_b !== exp_b()) begin
      miscompares++;
      $display("FAIL reset_b: got %h want %h", obs_b, exp_b());
    end
    vectors++;
    if ({bus_a.req_ready, busy_a, sel0_a, sel1_a, ioa} !== {1'b1, 1'b0, 32'h0, 32'h0, moa}) begin
      miscompares++;
      $display("FAIL reset_a_const: ready=%b busy=%b sel0=%h sel1=%h io=%h want 1 0 0 0 %h",
               bus_a.req_ready, busy_a, sel0_a, sel1_a, ioa, moa);
    end
  endtask

  task automatic test_switch();
    moa = '0;
    bus_a.req_valid = 1'b1;
    bus_a.req_pin   = 5'd3;
    bus_a.req_func  = 2'd2;
    clk_step();
    bus_a.req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      vectors++;
      if ({ioa[3], sel1_a[3], sel0_a[3], bus_a.done, busy_a} !==
          {c <= 8, c >= 5, 1'b0, c == 9, c <= 8}) begin
        miscompares++;
        $display("FAIL switch_c%0d: io3,sel3,done,busy=%b%b%b%b%b want %b%b%b%b%b", c,
                 ioa[3], sel1_a[3], sel0_a[3], bus_a.done, busy_a,
                 c <= 8, c >= 5, 1'b0, c == 9, c <= 8);
      end
      vectors++;
      if (obs_a !== exp_a()) begin
        miscompares++;
        $display("FAIL switch_model_c%0d: got %h want %h", c, obs_a, exp_a());
      end
      clk_step();
    end
  endtask

  task automatic test_fast();
    moa = $urandom();
    bus_a.req_valid = 1'b1;
    bus_a.req_pin   = 5'd5;
    bus_a.req_func  = 2'd0;
    clk_step();
    bus_a.req_valid = 1'b0;
    vectors++;
    if ({bus_a.done, bus_a.err, busy_a, ioa[5], sel1_a[5], sel0_a[5]} !==
        {1'b1, 1'b0, 1'b0, moa[5], 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL fast_path: done,err,busy,io5,sel5=%b%b%b%b%b%b want 100%b00",
               bus_a.done, bus_a.err, busy_a, ioa[5], sel1_a[5], sel0_a[5], moa[5]);
    end
    vectors++;
    if (obs_a !== exp_a()) begin
      miscompares++;
      $display("FAIL fast_model: got %h want %h", obs_a, exp_a());
    end
    clk_step();
    vectors++;
    if (bus_a.done !== 1'b0) begin
      miscompares++;
      $display("FAIL fast_single_pulse: done=%b want 0", bus_a.done);
    end
  endtask

  task automatic test_guard1();
    mob = '0;
    bus_b.req_valid = 1'b1;
    bus_b.req_pin   = 5'd0;
    bus_b.req_func  = 2'd1;
    clk_step();
    bus_b.req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      vectors++;
      if ({iob[0], sel1_b[0], sel0_b[0], bus_b.done} !== {c <= 2, 1'b0, c >= 2, c == 3}) begin
        miscompares++;
        $display("FAIL guard1_c%0d: io0,sel0,done=%b%b%b%b want %b0%b%b", c,
                 iob[0], sel1_b[0], sel0_b[0], bus_b.done, c <= 2, c >= 2, c == 3);
      end
      vectors++;
      if (obs_b !== exp_b()) begin
        miscompares++;
        $display("FAIL guard1_model_c%0d: got %h want %h", c, obs_b, exp_b());
      end
      clk_step();
    end
  endtask

  task automatic test_reject();
    mob = 20'($urandom());
    bus_b.req_valid = 1'b1;
    bus_b.req_pin   = 5'd25;
    bus_b.req_func  = 2'd3;
    clk_step();
    bus_b.req_valid = 1'b0;
    vectors++;
    if ({bus_b.err, bus_b.done, busy_b, sel0_b[0]} !== 4'b1001) begin
      miscompares++;
      $display("FAIL reject: err,done,busy,sel0[0]=%b%b%b%b want 1001",
               bus_b.err, bus_b.done, busy_b, sel0_b[0]);
    end
    vectors++;
    if (obs_b !== exp_b()) begin
      miscompares++;
      $display("FAIL reject_model: got %h want %h", obs_b, exp_b());
    end
  endtask

  task automatic test_back_to_back();
    int first_done;
    int second_done;
    first_done  = -1;
    second_done = -1;
    moa = '0;
    bus_a.req_valid = 1'b1;
    bus_a.req_pin   = 5'd10;
    bus_a.req_func  = 2'd1;
    clk_step();
    bus_a.req_pin  = 5'd11;
    bus_a.req_func = 2'd3;
    for (int c = 1; c <= 22; c++) begin
      if (bus_a.done === 1'b1) begin
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
      vectors++;
      if (obs_a !== exp_a()) begin
        miscompares++;
        $display("FAIL b2b_model_c%0d: got %h want %h", c, obs_a, exp_a());
      end
      if (c == 10) bus_a.req_valid = 1'b0;
      clk_step();
    end
    vectors++;
    if (first_done != 9 || second_done != 18) begin
      miscompares++;
      $display("FAIL b2b_done_cycles: got %0d,%0d want 9,18", first_done, second_done);
    end
    vectors++;
    if ({sel1_a[10], sel0_a[10], sel1_a[11], sel0_a[11]} !== 4'b0111) begin
      miscompares++;
      $display("FAIL b2b_sel: pin10=%b%b pin11=%b%b want 01 11",
               sel1_a[10], sel0_a[10], sel1_a[11], sel0_a[11]);
    end
  endtask

  task automatic test_reset_abort();
    moa = $urandom();
    bus_a.req_valid = 1'b1;
    bus_a.req_pin   = 5'd7;
    bus_a.req_func  = 2'd3;
    clk_step();
    bus_a.req_valid = 1'b0;
    for (int c = 1; c < 6; c++) clk_step();
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    vectors++;
    if ({sel0_a, sel1_a, ioa, bus_a.req_ready, bus_a.done} !== {32'h0, 32'h0, moa, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL abort: sel0=%h sel1=%h io=%h ready=%b done=%b want 0 0 %h 1 0",
               sel0_a, sel1_a, ioa, bus_a.req_ready, bus_a.done, moa);
    end
    for (int c = 0; c < 5; c++) begin
      clk_step();
      vectors++;
      if (bus_a.done !== 1'b0 || obs_a !== exp_a()) begin
        miscompares++;
        $display("FAIL abort_after_%0d: got %h want %h", c, obs_a, exp_a());
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      moa = $urandom();
      mob = 20'($urandom());
      bus_a.req_valid = ($urandom_range(0, 1) == 1);
      bus_a.req_pin   = 5'($urandom_range(0, 31));
      bus_a.req_func  = 2'($urandom_range(0, 3));
      bus_b.req_valid = ($urandom_range(0, 1) == 1);
      bus_b.req_pin   = 5'($urandom_range(0, 31));
      bus_b.req_func  = 2'($urandom_range(0, 3));
      clk_step();
      vectors++;
      if (obs_a !== exp_a()) begin
        miscompares++;
        $display("FAIL random_a_%0d: got %h want %h", n, obs_a, exp_a());
      end
      vectors++;
      if (obs_b !== exp_b()) begin
        miscompares++;
        $display("FAIL random_b_%0d: got %h want %h", n, obs_b, exp_b());
      end
    end
    rst = 1'b0;
    bus_a.req_valid = 1'b0;
    bus_b.req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    moa = '0;
    mob = '0;
    bus_a.req_valid = 1'b0;
    bus_a.req_pin   = '0;
    bus_a.req_func  = '0;
    bus_b.req_valid = 1'b0;
    bus_b.req_pin   = '0;
    bus_b.req_func  = '0;
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0;
      m_pin[k]   = 0;
      m_nf[k]    = 0;
      m_done[k]  = 0;
      m_err[k]   = 0;
      for (int i = 0; i < 64; i++) m_func[k][i] = 0;
    end
    @(negedge clk);
    test_reset();
    test_switch();
    test_fast();
    test_guard1();
    test_reject();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pin_mux_sel_ctrl.md
PIN_MUX_SEL_CTRL -- requirements
Module: pin_mux_sel_ctrl

Interface
REQ-001 Parameter COUNT, default 32: number of muxed pins, 2 to 64.
REQ-002 Parameter GUARD, default 4: tristate guard length in cycles, 1 to 255.
REQ-003 Derived width PW = clog2(COUNT), minimum 1.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 req_valid  input  1: reconfiguration request present.
REQ-007 req_ready  output  1: controller can accept a request.
REQ-008 req_pin  input  PW: index of the pin to reconfigure.
REQ-009 req_func  input  2: new function number for the pin (0..3).
REQ-010 done  output  1: one-cycle pulse when a request completes.
REQ-011 err  output  1: one-cycle pulse when a request is rejected.
REQ-012 busy  output  1: a switch sequence is in progress.
REQ-013 sel0  output  COUNT: per-pin function select, bit 0; feeds the pin mux.
REQ-014 sel1  output  COUNT: per-pin function select, bit 1; feeds the pin mux.
REQ-015 mux_oeb  input  COUNT: pad output-enable-bar from the pin mux (1 = pad tristated).
REQ-016 io_oeb  output  COUNT: gated pad output-enable-bar, driven to the pads.

Function
REQ-017 io_oeb[i] SHALL be combinational: mux_oeb[i] OR force[i], where force is an internal registered COUNT-bit vector.
REQ-018 The FSM SHALL have states IDLE, QUIESCE and SETTLE.
REQ-019 req_ready SHALL be 1 only in IDLE.
REQ-020 busy SHALL be 1 exactly when the state is not IDLE.
REQ-021 A handshake SHALL occur at edge T when req_valid=1 and req_ready=1; req_pin and req_func SHALL be captured at that edge.
REQ-022 Reject: if captured req_pin >= COUNT, err=1 in cycle T+1, the state stays IDLE, and no sel or force bit changes.
REQ-023 Fast path: if captured req_func equals the pin's current {sel1,sel0}, done=1 in cycle T+1, the state stays IDLE, and no force bit is set.
REQ-024 Switch path (otherwise): the state SHALL be QUIESCE from cycle T+1 and force[pin]=1 from cycle T+1.
REQ-025 QUIESCE SHALL last GUARD cycles, counted by a down-counter loaded with GUARD-1.
REQ-026 On the counter reaching 0 in QUIESCE: {sel1[pin],sel0[pin]} SHALL update to req_func (visible from cycle T+1+GUARD), the counter SHALL reload, and the state SHALL become SETTLE.
REQ-027 SETTLE SHALL last GUARD cycles with force[pin] still 1.
REQ-028 On the counter reaching 0 in SETTLE: force[pin] SHALL clear and the state SHALL become IDLE.
REQ-029 At the end of SETTLE, done=1 and req_ready=1 in cycle T+1+2*GUARD.
REQ-030 A new request MAY handshake in the same cycle that done is high.
REQ-031 Only the addressed pin's sel and force bits SHALL change during a request; all other pins are unaffected.
REQ-032 At most one force bit SHALL be 1 at any time.
REQ-033 done and err SHALL never both be 1, and each SHALL be high for exactly one cycle per request.
REQ-034 req_valid while not ready SHALL be ignored; it requires no stall and causes no state change.
REQ-035 Changes to req_pin or req_func after the handshake SHALL have no effect on the request in progress.

Reset
REQ-036 While rst=1 at a clock edge: state=IDLE, counter=0, sel0=0, sel1=0, force=0, done=0, err=0.
REQ-037 After that reset edge, busy=0 and req_ready=1.
REQ-038 Reset during QUIESCE or SETTLE SHALL abort the sequence with no done pulse, and every pin returns to function 0 with force cleared.
REQ-039 io_oeb SHALL equal mux_oeb from the first cycle after reset.

Verification
REQ-040 Reset release, then request pin 3 func 2 at T (GUARD=4) -> io_oeb[3]=1 during T+1..T+8; sel bits for pin 3 = 2 from T+5; done pulse at T+9; busy=1 during T+1..T+8.
REQ-041 Request pin 5 func 0 right after reset -> done at T+1; no io_oeb[5] forcing; sel unchanged.
REQ-042 COUNT=20, request pin 25 -> err at T+1; sel0, sel1 and io_oeb equal their pre-request values.
REQ-043 req_valid held high with a different pin during busy -> no handshake until done; the second request handshakes in the done cycle; its done arrives 2*GUARD+1 cycles later.
REQ-044 rst=1 at T+6 of a pin 7 func 3 switch -> next cycle all sel=0, io_oeb=mux_oeb, req_ready=1; no done pulse.
REQ-045 GUARD=1, request pin 0 func 1 -> force during T+1..T+2; sel updated from T+2; done at T+3.
